// File: rtl/connect_inject_pkg.sv
// Shared types and helpers for multi_vc_inject_port (optional checker: INJECT_CREDIT_CHECK_EN).
// Supplies codebase defaults for `FLIT_WIDTH / `FLIT_BUFFER_DEPTH when not set globally.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 16
`endif
`ifndef FLIT_BUFFER_DEPTH
`define FLIT_BUFFER_DEPTH 4
`endif

package connect_inject_pkg;

    localparam int unsigned NUM_VCS_DFLT   = 2;
    localparam int unsigned CREDIT_VC_BITS = ($clog2(NUM_VCS_DFLT) > 1) ? $clog2(NUM_VCS_DFLT) : 1;
    localparam int unsigned FLIT_VALID_BIT = `FLIT_WIDTH - 1;
    localparam int unsigned FLIT_VC_MSB    = `FLIT_WIDTH - 2;

    // Arbiter search width; NUM_VCS must not exceed RR_MAX_VCS.
    localparam int unsigned RR_MAX_VCS  = 16;
    localparam int unsigned RR_IDX_BITS = 4;

    typedef struct packed {
        logic                      valid;
        logic [CREDIT_VC_BITS-1:0] vc;
    } credit_t;

    typedef struct packed {
        logic                   found;
        logic [RR_IDX_BITS-1:0] idx;
    } rr_pick_t;

    function automatic rr_pick_t rr_pick(input logic [RR_MAX_VCS-1:0] eligible,
                                         input int unsigned ptr,
                                         input int unsigned num);
        rr_pick_t    r;
        int unsigned j;
        r = '0;
        for (int unsigned i = 0; i < RR_MAX_VCS; i++) begin
            if (i < num) begin
                j = ptr + i;
                if (j >= num) j = j - num;
                if (!r.found && eligible[RR_IDX_BITS'(j)]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDX_BITS'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/multi_vc_inject_port_queue.sv
// Per-VC circular flit buffer; full/empty split by a maybe_full bit since pointers wrap modulo DEPTH.
module vc_flit_queue #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] enq_data,
    input  logic             enq_valid,
    output logic             enq_ready,
    output logic [WIDTH-1:0] deq_data,
    output logic             deq_valid,
    input  logic             deq_pop
);
    localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [PTR_BITS-1:0] wr_ptr;
    logic [PTR_BITS-1:0] rd_ptr;
    logic                maybe_full;
    logic                full;
    logic                empty;
    logic                do_enq;
    logic                do_deq;

    assign full      = (wr_ptr == rd_ptr) && maybe_full;
    assign empty     = (wr_ptr == rd_ptr) && !maybe_full;
    assign enq_ready = !full;
    assign deq_valid = !empty;
    assign deq_data  = mem[rd_ptr];
    assign do_enq    = enq_valid && !full;
    assign do_deq    = deq_pop && !empty;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) wr_ptr <= wr_ptr + PTR_BITS'(1);
            if (do_deq) rd_ptr <= rd_ptr + PTR_BITS'(1);
            if (do_enq != do_deq) maybe_full <= do_enq;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_enq) mem[wr_ptr] <= enq_data;
    end

endmodule

// File: rtl/multi_vc_inject_port.sv
// Multi-VC injection port: per-VC queues, per-VC credit counters, round-robin link arbiter.
// Optional credit-overflow checker enabled by macro INJECT_CREDIT_CHECK_EN.
module multi_vc_inject_port
    import connect_inject_pkg::*;
#(
    parameter int unsigned NUM_VCS      = 2,
    parameter int unsigned VC_BITS      = ($clog2(NUM_VCS) > 1) ? $clog2(NUM_VCS) : 1,
    parameter int unsigned FLIT_WIDTH   = `FLIT_WIDTH,
    parameter int unsigned DEPTH        = `FLIT_BUFFER_DEPTH,
    parameter int unsigned CREDITS_INIT = `FLIT_BUFFER_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [FLIT_WIDTH-1:0] put_flit,
    input  logic [VC_BITS-1:0]    put_vc,
    input  logic                  put_valid,
    output logic                  put_ready,
    output logic [FLIT_WIDTH-1:0] link_flit,
    output logic                  link_en,
    input  logic [VC_BITS:0]      credit_in,
    output logic                  credit_err
);
    localparam int unsigned     CW       = $clog2(CREDITS_INIT + 1);
    localparam logic [CW-1:0]   CRED_MAX = CW'(CREDITS_INIT);

    logic [NUM_VCS-1:0]    q_enq_valid;
    logic [NUM_VCS-1:0]    q_enq_ready;
    logic [NUM_VCS-1:0]    q_deq_valid;
    logic [NUM_VCS-1:0]    q_pop;
    logic [NUM_VCS-1:0]    eligible;
    logic [NUM_VCS-1:0]    ret;
    logic [FLIT_WIDTH-1:0] q_head [NUM_VCS];
    logic [CW-1:0]         credits [NUM_VCS];
    logic [VC_BITS-1:0]    rr_ptr;
    logic                  credit_valid;
    logic [VC_BITS-1:0]    credit_vc;
    logic [RR_MAX_VCS-1:0] elig_ext;
    logic [FLIT_WIDTH-1:0] grant_flit;
    rr_pick_t              pick;

    assign credit_valid = credit_in[VC_BITS];
    assign credit_vc    = credit_in[VC_BITS-1:0];

    for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
        assign q_enq_valid[v] = put_valid && (32'(put_vc) == v);
        assign eligible[v]    = q_deq_valid[v] && (credits[v] != '0);
        assign q_pop[v]       = pick.found && (32'(pick.idx) == v);
        assign ret[v]         = credit_valid && (32'(credit_vc) == v);

        vc_flit_queue #(
            .WIDTH (FLIT_WIDTH),
            .DEPTH (DEPTH)
        ) u_queue (
            .CLK       (CLK),
            .RST_N     (RST_N),
            .enq_data  (put_flit),
            .enq_valid (q_enq_valid[v]),
            .enq_ready (q_enq_ready[v]),
            .deq_data  (q_head[v]),
            .deq_valid (q_deq_valid[v]),
            .deq_pop   (q_pop[v])
        );
    end

    // Out-of-range put_vc matches no queue, so it is never ready.
    always_comb begin
        put_ready = 1'b0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (32'(put_vc) == v) put_ready = q_enq_ready[v];
        end
    end

    always_comb begin
        elig_ext                = '0;
        elig_ext[NUM_VCS-1:0]   = eligible;
        pick                    = rr_pick(elig_ext, 32'(rr_ptr), NUM_VCS);
        grant_flit              = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (q_pop[v]) grant_flit = q_head[v];
        end
        grant_flit[FLIT_WIDTH-1]             = 1'b1;
        grant_flit[FLIT_WIDTH-2 -: VC_BITS]  = VC_BITS'(pick.idx);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            link_en   <= 1'b0;
            link_flit <= '0;
            rr_ptr    <= '0;
        end else if (pick.found) begin
            link_en   <= 1'b1;
            link_flit <= grant_flit;
            rr_ptr    <= (32'(pick.idx) == NUM_VCS - 1) ? '0 : VC_BITS'(32'(pick.idx) + 1);
        end else begin
            link_en   <= 1'b0;
            link_flit <= '0;
        end
    end

    // Grant and return on the same VC cancel; returns at full credit saturate.
    always_ff @(posedge CLK) begin
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            if (!RST_N) begin
                credits[v] <= CRED_MAX;
            end else if (q_pop[v] && !ret[v]) begin
                credits[v] <= credits[v] - CW'(1);
            end else if (ret[v] && !q_pop[v] && (credits[v] != CRED_MAX)) begin
                credits[v] <= credits[v] + CW'(1);
            end
        end
    end

`ifdef INJECT_CREDIT_CHECK_EN
    logic [NUM_VCS-1:0] overflow;

    always_comb begin
        overflow = '0;
        for (int unsigned v = 0; v < NUM_VCS; v++) begin
            overflow[v] = ret[v] && !q_pop[v] && (credits[v] == CRED_MAX);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N)         credit_err <= 1'b0;
        else if (|overflow) credit_err <= 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST_N) begin
            assert (!(|overflow)) else $error("credit overflow on vc %0d", credit_vc);
        end
    end
`else
    assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_multi_vc_inject_port.sv
// Self-checking bench for multi_vc_inject_port: vector table plus directed credit/arbitration/reset sequences.
module tb_multi_vc_inject_port;

    logic        CLK;
    logic        RST_N;
    logic [15:0] put_flit;
    logic [0:0]  put_vc;
    logic        put_valid;
    logic        put_ready;
    logic [15:0] link_flit;
    logic        link_en;
    logic [1:0]  credit_in;
    logic        credit_err;

    int compared   = 0;
    int mismatched = 0;
    int link_cnt   = 0;
    int lc;
    logic [15:0] exp_q[$];

`ifdef INJECT_CREDIT_CHECK_EN
    localparam logic CE_AFTER_OVF = 1'b1;
`else
    localparam logic CE_AFTER_OVF = 1'b0;
`endif

    typedef struct {
        logic [0:0]  vc;
        logic [15:0] data;
        logic        exp_ready;
    } vec_t;
    vec_t tbl[8];

    multi_vc_inject_port #(
        .NUM_VCS      (2),
        .VC_BITS      (1),
        .FLIT_WIDTH   (16),
        .DEPTH        (4),
        .CREDITS_INIT (4)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .put_flit   (put_flit),
        .put_vc     (put_vc),
        .put_valid  (put_valid),
        .put_ready  (put_ready),
        .link_flit  (link_flit),
        .link_en    (link_en),
        .credit_in  (credit_in),
        .credit_err (credit_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] ef(input logic [0:0] vc, input logic [15:0] d);
        return {1'b1, vc, d[13:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every emitted link flit must match the next expected flit.
    always @(negedge CLK) begin
        if (link_en === 1'b1) begin
            link_cnt++;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_link_flit: actual 0x%0h, required none", link_flit);
            end else begin
                check("link_flit", {16'h0, link_flit}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put_one(input logic [0:0] vc, input logic [15:0] d, input logic push);
        put_vc    = vc;
        put_flit  = d;
        put_valid = 1'b1;
        if (push) exp_q.push_back(ef(vc, d));
        tick();
        put_valid = 1'b0;
    endtask

    task automatic do_reset();
        RST_N     = 1'b0;
        put_valid = 1'b0;
        put_vc    = '0;
        put_flit  = '0;
        credit_in = '0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            tbl[i].vc        = 1'(i % 2);
            tbl[i].data      = 16'(32'hC0A0 + i * 257);
            tbl[i].exp_ready = 1'b1;
        end

        // Reset values and single-flit latency
        do_reset();
        #1;
        check("rst_link_en", link_en, 0);
        check("rst_link_flit", link_flit, 0);
        check("rst_credit_err", credit_err, 0);
        check("rst_put_ready", put_ready, 1);
        put_one(1'b0, 16'h005A, 1'b1);
        check("t1_link_en_t1", link_en, 0);
        tick();
        check("t1_link_en_t2", link_en, 1);
        check("t1_link_flit", link_flit, 16'h805A);
        tick();
        check("t1_link_en_t3", link_en, 0);

        // Interleaved puts: alternating VCs, continuous link
        do_reset();
        for (int i = 0; i < 8; i++) begin
            put_vc    = tbl[i].vc;
            put_flit  = tbl[i].data;
            put_valid = 1'b1;
            #1;
            check("t3_put_ready", put_ready, tbl[i].exp_ready);
            exp_q.push_back(ef(tbl[i].vc, tbl[i].data));
            tick();
            if (i > 0) check("t3_link_en", link_en, 1);
        end
        put_valid = 1'b0;
        tick();
        check("t3_link_en_last", link_en, 1);
        tick();
        check("t3_link_en_idle", link_en, 0);

        // Overflow return saturates; then credit-limited sends
        do_reset();
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;
        check("ovf_credit_err", credit_err, CE_AFTER_OVF);
        lc = link_cnt;
        for (int i = 0; i < 6; i++) put_one(1'b0, 16'(32'h0100 + i), (i < 5));
        tick(); tick(); tick(); tick();
        check("t4_sent_count", link_cnt - lc, 4);
        check("t4_stalled", link_en, 0);
        credit_in = 2'b10;
        tick();
        credit_in = 2'b00;
        check("t4_ret_t0", link_en, 0);
        tick();
        check("t4_ret_t1", link_en, 1);
        tick();
        check("t4_ret_t2", link_en, 0);

        // Contention: vc0 unblocked by credit while vc1 gets a flit; rr_ptr favours vc1
        credit_in = 2'b10;
        put_vc    = 1'b1;
        put_flit  = 16'h7777;
        put_valid = 1'b1;
        exp_q.push_back(ef(1'b1, 16'h7777));
        exp_q.push_back(ef(1'b0, 16'h0105));
        tick();
        put_valid = 1'b0;
        credit_in = 2'b00;
        tick();
        check("rr_first_en", link_en, 1);
        check("rr_first_vc", link_flit[14], 1);
        tick();
        check("rr_second_en", link_en, 1);
        check("rr_second_vc", link_flit[14], 0);
        tick();
        check("rr_idle", link_en, 0);

        // Exhaust vc1 credits, then fill its queue
        for (int i = 0; i < 3; i++) put_one(1'b1, 16'(32'h2200 + i), 1'b1);
        tick(); tick();
        for (int i = 0; i < 4; i++) put_one(1'b1, 16'(32'h2300 + i), 1'b0);
        put_vc = 1'b1;
        #1;
        check("t2_ready_vc1_full", put_ready, 0);
        put_vc = 1'b0;
        #1;
        check("t2_ready_vc0", put_ready, 1);
        check("t2_no_send", link_en, 0);

        // Same-cycle grant and return on vc1 leaves credits unchanged
        exp_q.push_back(ef(1'b1, 16'h2300));
        exp_q.push_back(ef(1'b1, 16'h2301));
        credit_in = 2'b11;
        tick();
        check("t5_t0", link_en, 0);
        tick();
        credit_in = 2'b00;
        check("t5_t1", link_en, 1);
        tick();
        check("t5_t2", link_en, 1);
        tick();
        check("t5_t3", link_en, 0);
        tick();
        check("t5_t4", link_en, 0);
        check("t5_credit_err", credit_err, CE_AFTER_OVF);

        // Reset with 3 flits queued: discarded, credits restored
        put_one(1'b0, 16'h3333, 1'b0);
        RST_N = 1'b0;
        tick();
        check("t6_link_en", link_en, 0);
        check("t6_link_flit", link_flit, 0);
        RST_N = 1'b1;
        lc = link_cnt;
        tick(); tick(); tick(); tick(); tick();
        check("t6_no_stale", link_cnt - lc, 0);
        check("t6_credit_err", credit_err, 0);
        for (int i = 0; i < 4; i++) put_one(1'b0, 16'(32'h4400 + i), 1'b1);
        tick(); tick(); tick();
        check("t6_full_credits", link_cnt - lc, 4);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
